vit_stage_ctrl: RTL and testbench
=================================

Name: vit_stage_ctrl

Overview:
- Per-symbol sequencer for the 64-state hard-decision Viterbi decoder.
- Accepts received symbol pairs over a valid/ready handshake, latches each pair for the branch-metric units, and steps the shared ACS array through NUM_GROUPS time-multiplexed butterfly groups.
- Drives survivor-memory writes, path-metric bank swap and metric normalization.
- Counts trellis stages per frame, triggers traceback at frame end and stalls input until traceback completes.

Parameters:
- NUM_GROUPS, 8: ACS passes per symbol (64 states / 8 ACS units).
- GRP_W, 3: width of the group index, equal to clog2(NUM_GROUPS).
- FRAME_LEN, 64: maximum stages per frame.
- SMEM_AW, 6: survivor-memory stage address width, equal to clog2(FRAME_LEN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  symbol pair valid.
- rx_pair  in  2  hard-decision received pair.
- rx_last  in  1  marks the final symbol of a frame; qualified by rx_valid.
- rx_ready  out  1  controller can accept a symbol.
- bmc_rx_pair  out  2  latched pair feeding all BMC instances.
- acs_en  out  1  ACS array enable.
- acs_grp  out  GRP_W  butterfly group index.
- acs_first  out  1  first stage of frame; ACS uses initial metrics.
- sm_swap  out  1  one-cycle pulse: swap path-metric banks.
- norm_req  in  1  ACS reports a metric MSB set.
- norm_en  out  1  ACS subtracts the normalization offset.
- smem_we  out  1  survivor-memory write enable.
- smem_waddr  out  SMEM_AW  stage address.
- smem_wgrp  out  GRP_W  group column within the stage word.
- tb_start  out  1  one-cycle traceback start pulse.
- tb_len  out  SMEM_AW+1  number of stages in the frame.
- tb_done  in  1  traceback finished (pulse).
- busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, ACS, SWAP, TB_WAIT. Reset state is IDLE.
- All outputs are registered or decoded directly from state and counter registers; no combinational path from inputs to outputs.
- Reset values: rx_ready=1 (IDLE decode); all other outputs 0; grp=0; stage_cnt=0; last_flag=0; norm_pend=0.
- IDLE: rx_ready=1. On rx_valid&rx_ready: latch rx_pair into bmc_rx_pair, rx_last into last_flag; set grp=0; go to ACS.
- ACS: acs_en=1, acs_grp=grp, smem_we=1, smem_waddr=stage_cnt, smem_wgrp=grp, acs_first=(stage_cnt==0).
  - grp increments each cycle.
  - When grp==NUM_GROUPS-1, go to SWAP.
  - Exactly NUM_GROUPS ACS cycles per symbol.
- SWAP: sm_swap=1 for one cycle.
  - If stage_cnt==FRAME_LEN-1 or last_flag: tb_start=1, tb_len=stage_cnt+1, go to TB_WAIT.
  - Otherwise stage_cnt+=1 and go to IDLE.
- TB_WAIT: rx_ready=0. On tb_done: stage_cnt=0, last_flag=0, go to IDLE. Without tb_done the block waits indefinitely.
- tb_done outside TB_WAIT is ignored.
- rx_valid is ignored when rx_ready=0. bmc_rx_pair holds its value outside accept cycles.
- Normalization:
  - norm_req sampled high in any ACS cycle sets norm_pend.
  - At SWAP, norm_pend moves to norm_en, which then holds for all NUM_GROUPS ACS cycles of the next stage, then clears.
  - A norm_req during a normalizing stage re-arms norm_pend for the following stage.
  - norm_en is never asserted on a stage with acs_first=1; a pending request is discarded at traceback.
- Timing:
  - Accept at cycle t; ACS at t+1..t+NUM_GROUPS; SWAP at t+NUM_GROUPS+1; rx_ready high again at t+NUM_GROUPS+2.
  - Peak throughput is one symbol per NUM_GROUPS+2 cycles.
- Wrap-around: stage_cnt never exceeds FRAME_LEN-1. A full frame forces traceback regardless of rx_last.
- Reset asserted mid-operation: immediate return to IDLE with the reset values above. Any in-flight stage is abandoned, with no partial sm_swap or tb_start.

Test Plan:
- Reset: rst_n low, then released → rx_ready=1, acs_en=0, smem_we=0, tb_start=0, busy=0, stage_cnt=0.
- Single symbol rx_pair=2'b10 accepted at cycle 0 →
  - bmc_rx_pair=2'b10;
  - acs_grp 0..7 on cycles 1..8 with smem_waddr=0 and acs_first=1;
  - sm_swap at cycle 9;
  - rx_ready=1 at cycle 10.
- Back-to-back valid stream of 64 symbols →
  - rx_ready low 9 of every 10 cycles;
  - smem_waddr 0..63;
  - tb_start with tb_len=64 after the 64th SWAP;
  - rx_ready=0 until tb_done, then stage_cnt=0.
- Short frame of 5 symbols with rx_last on the 5th → tb_start with tb_len=5; the 6th symbol is accepted only after tb_done and uses acs_first=1.
- norm_req pulsed during group 3 of stage 2 → norm_en=1 for all 8 ACS cycles of stage 3 and 0 in stage 4.
- tb_done pulsed while in IDLE, then reset asserted during ACS group 4 → no effect from the stray tb_done; outputs return to reset values asynchronously and no sm_swap is issued.

Source files
------------

// File: rtl/vit_stage_ctrl.sv
// Per-symbol sequencer for the 64-state hard-decision Viterbi decoder: accepts
// symbol pairs, steps the ACS array through its butterfly groups, manages frames.
module vit_stage_ctrl #(
  parameter int NUM_GROUPS = 8,
  parameter int GRP_W      = 3,
  parameter int FRAME_LEN  = 64,
  parameter int SMEM_AW    = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_valid,
  input  logic [1:0]         rx_pair,
  input  logic               rx_last,
  output logic               rx_ready,
  output logic [1:0]         bmc_rx_pair,
  output logic               acs_en,
  output logic [GRP_W-1:0]   acs_grp,
  output logic               acs_first,
  output logic               sm_swap,
  input  logic               norm_req,
  output logic               norm_en,
  output logic               smem_we,
  output logic [SMEM_AW-1:0] smem_waddr,
  output logic [GRP_W-1:0]   smem_wgrp,
  output logic               tb_start,
  output logic [SMEM_AW:0]   tb_len,
  input  logic               tb_done,
  output logic               busy
);

  // Handshake: a symbol transfers on a rising clk edge where rx_valid && rx_ready;
  // rx_ready depends only on state, and rx_valid is ignored while rx_ready is low.
  typedef enum logic [1:0] {IDLE, ACS, SWAP, TB_WAIT} state_t;

  state_t             state, state_nxt;
  logic [GRP_W-1:0]   grp;
  logic [SMEM_AW-1:0] stage_cnt;
  logic [1:0]         pair_q;
  logic               last_flag;
  logic               norm_pend;
  logic               norm_arm;
  logic               frame_end;

  assign frame_end = (stage_cnt == SMEM_AW'(FRAME_LEN - 1)) || last_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_valid) state_nxt = ACS;
      ACS:     if (grp == GRP_W'(NUM_GROUPS - 1)) state_nxt = SWAP;
      SWAP:    state_nxt = frame_end ? TB_WAIT : IDLE;
      TB_WAIT: if (tb_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // norm_arm is reloaded at every SWAP, so it covers exactly the next stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp       <= '0;
      stage_cnt <= '0;
      pair_q    <= '0;
      last_flag <= 1'b0;
      norm_pend <= 1'b0;
      norm_arm  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            pair_q    <= rx_pair;
            last_flag <= rx_last;
            grp       <= '0;
          end
        end
        ACS: begin
          grp <= grp + GRP_W'(1);
          if (norm_req) norm_pend <= 1'b1;
        end
        SWAP: begin
          norm_pend <= 1'b0;
          if (frame_end) begin
            norm_arm <= 1'b0;
          end else begin
            norm_arm  <= norm_pend;
            stage_cnt <= stage_cnt + SMEM_AW'(1);
          end
        end
        TB_WAIT: begin
          if (tb_done) begin
            stage_cnt <= '0;
            last_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rx_ready    = (state == IDLE);
    busy        = (state != IDLE);
    bmc_rx_pair = pair_q;
    acs_en      = (state == ACS);
    acs_grp     = grp;
    acs_first   = (state == ACS) && (stage_cnt == '0);
    norm_en     = (state == ACS) && norm_arm;
    smem_we     = (state == ACS);
    smem_waddr  = stage_cnt;
    smem_wgrp   = grp;
    sm_swap     = (state == SWAP);
    tb_start    = (state == SWAP) && frame_end;
    tb_len      = '0;
    if (((state == SWAP) && frame_end) || (state == TB_WAIT))
      tb_len = {1'b0, stage_cnt} + (SMEM_AW + 1)'(1);
  end

endmodule

// File: tb/tb_vit_stage_ctrl.sv
// Directed bench for vit_stage_ctrl: single symbol, full frame, short frame,
// normalization, stray tb_done and mid-stage reset.
module tb_vit_stage_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [1:0] rx_pair = 2'b00;
  logic       rx_last = 1'b0;
  logic       norm_req = 1'b0;
  logic       tb_done = 1'b0;
  logic       rx_ready, acs_en, acs_first, sm_swap, norm_en, smem_we, tb_start, busy;
  logic [1:0] bmc_rx_pair;
  logic [2:0] acs_grp, smem_wgrp;
  logic [5:0] smem_waddr;
  logic [6:0] tb_len;

  int n_cmp = 0;
  int n_err = 0;

  vit_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_pair(rx_pair),
    .rx_last(rx_last), .rx_ready(rx_ready), .bmc_rx_pair(bmc_rx_pair),
    .acs_en(acs_en), .acs_grp(acs_grp), .acs_first(acs_first), .sm_swap(sm_swap),
    .norm_req(norm_req), .norm_en(norm_en), .smem_we(smem_we),
    .smem_waddr(smem_waddr), .smem_wgrp(smem_wgrp), .tb_start(tb_start),
    .tb_len(tb_len), .tb_done(tb_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rx_ready"}, rx_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_acs_en"}, acs_en, 0);
    chk({tag, "_smem_we"}, smem_we, 0);
    chk({tag, "_sm_swap"}, sm_swap, 0);
    chk({tag, "_tb_start"}, tb_start, 0);
    chk({tag, "_norm_en"}, norm_en, 0);
    chk({tag, "_acs_first"}, acs_first, 0);
  endtask

  // One symbol: accept, 8 ACS cycles, SWAP, then the cycle after SWAP.
  task automatic run_symbol(input logic [1:0] pair, input logic last,
                            input int addr, input logic first, input logic norm,
                            input int norm_grp, input logic tb);
    int w;
    w = 0;
    while (!rx_ready && w < 50) begin step(); w++; end
    chk("ready_before_accept", rx_ready, 1);
    rx_valid = 1'b1; rx_pair = pair; rx_last = last;
    step();
    rx_valid = 1'b0; rx_pair = ~pair; rx_last = 1'b0;
    for (int g = 0; g < 8; g++) begin
      chk("acs_en", acs_en, 1);
      chk("acs_grp", acs_grp, g);
      chk("smem_we", smem_we, 1);
      chk("smem_wgrp", smem_wgrp, g);
      chk("smem_waddr", smem_waddr, addr);
      chk("acs_first", acs_first, first);
      chk("norm_en", norm_en, norm);
      chk("bmc_rx_pair", bmc_rx_pair, pair);
      chk("rx_ready_acs", rx_ready, 0);
      chk("busy_acs", busy, 1);
      chk("sm_swap_acs", sm_swap, 0);
      chk("tb_start_acs", tb_start, 0);
      if (g == norm_grp) norm_req = 1'b1;
      step();
      norm_req = 1'b0;
    end
    chk("sm_swap", sm_swap, 1);
    chk("acs_en_swap", acs_en, 0);
    chk("rx_ready_swap", rx_ready, 0);
    chk("norm_en_swap", norm_en, 0);
    chk("tb_start", tb_start, tb);
    if (tb) chk("tb_len", tb_len, addr + 1);
    step();
    chk("sm_swap_after", sm_swap, 0);
    chk("tb_start_after", tb_start, 0);
    chk("rx_ready_after", rx_ready, !tb);
    chk("busy_after", busy, tb);
  endtask

  task automatic finish_traceback(input int len);
    rx_valid = 1'b1; rx_pair = 2'b11;
    for (int i = 0; i < 5; i++) begin
      chk("tbw_rx_ready", rx_ready, 0);
      chk("tbw_acs_en", acs_en, 0);
      chk("tbw_busy", busy, 1);
      chk("tbw_tb_start", tb_start, 0);
      chk("tbw_tb_len", tb_len, len);
      step();
    end
    rx_valid = 1'b0;
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    chk_idle("post_tb");
  endtask

  initial begin
    // Reset
    repeat (3) step();
    chk_idle("reset");
    chk("reset_bmc", bmc_rx_pair, 0);
    chk("reset_waddr", smem_waddr, 0);
    chk("reset_tb_len", tb_len, 0);
    rst_n = 1'b1;
    step();
    chk_idle("after_release");
    chk("after_release_waddr", smem_waddr, 0);

    // Single symbol, then the rest of a 64-symbol back-to-back frame with a
    // norm_req in group 3 of stage 2 that must normalize stage 3 only.
    run_symbol(2'b10, 1'b0, 0, 1'b1, 1'b0, -1, 1'b0);
    for (int s = 1; s < 64; s++) begin
      logic [5:0] sv;
      sv = 6'(s);
      run_symbol(sv[1:0], 1'b0, s, 1'b0, (s == 3), (s == 2) ? 3 : -1, (s == 63));
    end
    finish_traceback(64);

    // Short frame of 5, norm_req in the last stage is dropped at traceback.
    for (int s = 0; s < 5; s++)
      run_symbol(2'b01, (s == 4), s, (s == 0), 1'b0, (s == 4) ? 0 : -1, (s == 4));
    finish_traceback(5);
    run_symbol(2'b11, 1'b0, 0, 1'b1, 1'b0, -1, 1'b0);
    run_symbol(2'b00, 1'b0, 1, 1'b0, 1'b0, -1, 1'b0);

    // Stray tb_done in IDLE must not clear the stage count.
    tb_done = 1'b1;
    step();
    tb_done = 1'b0;
    chk_idle("stray_tb_done");
    rx_valid = 1'b1; rx_pair = 2'b10;
    step();
    rx_valid = 1'b0;
    chk("stray_waddr", smem_waddr, 2);
    chk("stray_first", acs_first, 0);
    repeat (4) step();
    chk("pre_reset_grp", acs_grp, 4);

    // Asynchronous reset mid-stage.
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_bmc", bmc_rx_pair, 0);
    chk("async_reset_grp", acs_grp, 0);
    chk("async_reset_waddr", smem_waddr, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("reset_no_swap", sm_swap, 0);
      chk("reset_no_tb_start", tb_start, 0);
    end
    rst_n = 1'b1;
    step();
    chk_idle("reset_release2");
    run_symbol(2'b01, 1'b0, 0, 1'b1, 1'b0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
